// File: rtl/cnn_acc_pkg.sv
// Shared types and widths for the CNN partial-sum accumulator slice.
// Optional feature macro: ACC_SATURATE_EN (see sat_add).
package cnn_acc_pkg;

   localparam int ACC_DATA_WIDTH  = 16;
   localparam int ACC_COUNT_WIDTH = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_t;

endpackage

// File: rtl/partial_sum_accumulator_sat_add.sv
// Combinational accumulator adder: wrap-around by default, signed saturating
// when ACC_SATURATE_EN is defined.
module sat_add
   import cnn_acc_pkg::*;
#(
   parameter int DATA_WIDTH = ACC_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] sum
);

   logic [DATA_WIDTH-1:0] raw_sum;

   assign raw_sum = a + b;

`ifdef ACC_SATURATE_EN
   logic overflow;

   // Overflow only when both operands share a sign the result does not.
   always_comb begin
      overflow = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                 (raw_sum[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      if (overflow && a[DATA_WIDTH-1])
         sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else if (overflow)
         sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
         sum = raw_sum;
   end
`else
   assign sum = raw_sum;
`endif

endmodule

// File: rtl/partial_sum_accumulator.sv
// Accumulates a programmed number of adder-tree partial sums into one pixel
// value; saturation is selected by ACC_SATURATE_EN inside sat_add.
module partial_sum_accumulator
   import cnn_acc_pkg::*;
#(
   parameter int DATA_WIDTH  = ACC_DATA_WIDTH,
   parameter int COUNT_WIDTH = ACC_COUNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] num_partials,
   input  logic [DATA_WIDTH-1:0]  bias,
   input  logic                   in_valid,
   input  logic [DATA_WIDTH-1:0]  in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [DATA_WIDTH-1:0]  out_data,
   input  logic                   out_ready,
   output logic                   busy
);

   acc_state_t             state;
   logic [DATA_WIDTH-1:0]  acc;
   logic [DATA_WIDTH-1:0]  acc_sum;
   logic [COUNT_WIDTH-1:0] remaining;

   sat_add #(.DATA_WIDTH(DATA_WIDTH)) u_sat_add (
      .a   (acc),
      .b   (in_data),
      .sum (acc_sum)
   );

   // The accumulator register doubles as the held result while in DONE.
   assign out_data = acc;

   // Handshake outputs are flopped alongside the state so no input reaches
   // them combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         remaining <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc  <= bias;
                  busy <= 1'b1;
                  if (num_partials != '0) begin
                     remaining <= num_partials;
                     in_ready  <= 1'b1;
                     state     <= ACCUM;
                  end else begin
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  acc       <= acc_sum;
                  remaining <= remaining - 1'b1;
                  if (remaining == COUNT_WIDTH'(1)) begin
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule
